// File: rtl/boot_rom_pkg.sv
// Shared defaults and state encoding for the boot ROM bus adapter.
package boot_rom_pkg;

  localparam int unsigned BOOT_ROM_WORDS = 839;
  localparam int unsigned BOOT_ROM_AW    = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/boot_rom_bus_adapter.sv
// Core request/response bus to synchronous boot ROM adapter, one response in flight.
// Optional BOOT_ROM_ADAPTER_ERR_EN: error responses for writes and out-of-range reads.
module boot_rom_bus_adapter
  import boot_rom_pkg::*;
#(
  parameter int unsigned ROM_WORDS = BOOT_ROM_WORDS,
  parameter int unsigned ROM_AW    = BOOT_ROM_AW
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  state_e            state_q, state_d;
  logic              rom_resp_q, rom_resp_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] word_idx;
  logic              synth;
  logic              synth_err;
  logic              grant;
  logic              rom_sel;

  assign word_idx = addr_i[ROM_AW+1:2];

`ifdef BOOT_ROM_ADAPTER_ERR_EN
  logic out_of_range;
  assign out_of_range = (32'(word_idx) >= ROM_WORDS);
  assign synth        = we_i | out_of_range;
  assign synth_err    = 1'b1;
`else
  assign synth        = we_i;
  assign synth_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rom_resp_d = rom_resp_q;
    err_d      = err_q;
    grant      = RSTN & req_i & ((state_q == IDLE) | rready_i);
    rom_sel    = grant & ~synth;
    // In RESP a grant implies rready_i, so the pending response retires this cycle.
    if (grant) begin
      state_d    = RESP;
      rom_resp_d = ~synth;
      err_d      = synth & synth_err;
    end else if ((state_q == RESP) && rready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      rom_resp_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_resp_q <= rom_resp_d;
      err_q      <= err_d;
    end
  end

  assign gnt_o     = grant;
  assign rom_csn_o = ~rom_sel;
  assign rom_a_o   = rom_sel ? word_idx : '0;
  assign rvalid_o  = (state_q == RESP);
  // ROM Q holds while a response is pending because no new select can happen until retire.
  assign rdata_o   = ((state_q == RESP) && rom_resp_q) ? rom_q_i : '0;
  assign err_o     = (state_q == RESP) & err_q;

  logic unused_ok;
  assign unused_ok = ^{be_i, wdata_i, addr_i[31:ROM_AW+2], addr_i[1:0]};

endmodule

// File: tb/tb_boot_rom_bus_adapter.sv
// Self-checking bench for boot_rom_bus_adapter with a behavioural ROM beside the DUT.
module tb_boot_rom_bus_adapter;

`ifdef BOOT_ROM_ADAPTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int unsigned WORDS = 839;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        req_i, we_i, rready_i;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, rom_csn_o;
  logic [31:0] rdata_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q = '0;
  logic [31:0] rom_mem [1024];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  boot_rom_bus_adapter #(.ROM_WORDS(WORDS), .ROM_AW(10)) dut (
    .CLK(CLK), .RSTN(RSTN), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
    .rom_csn_o(rom_csn_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q)
  );

  // Synchronous ROM: address latched on select, Q held until the next select.
  always @(posedge CLK) if (!rom_csn_o) rom_q <= rom_mem[rom_a_o];

  typedef struct {
    logic        rstn, req, we, rready;
    logic [31:0] addr;
    logic        gnt, csn;
    logic [9:0]  a;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  vec_t  tbl[$];
  resp_t exp_q[$];

  function automatic vec_t mk(logic rstn, logic req, logic we, logic rready, logic [31:0] addr,
                              logic gnt, logic csn, logic [9:0] a, logic rvalid,
                              logic [31:0] rdata, logic err);
    vec_t v;
    v.rstn = rstn; v.req = req; v.we = we; v.rready = rready; v.addr = addr;
    v.gnt = gnt; v.csn = csn; v.a = a; v.rvalid = rvalid; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic req, input logic we, input logic rready,
                       input logic [31:0] addr);
    RSTN = rstn; req_i = req; we_i = we; rready_i = rready; addr_i = addr;
    be_i = 4'($urandom); wdata_i = $urandom;
    #1;
  endtask

  task automatic adv;
    @(negedge CLK);
  endtask

  initial begin
    logic [9:0]  idx;
    logic [31:0] addr;
    logic        rstn, req, we, rdy, pending, eg, esynth;
    resp_t       r;

    for (int unsigned i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h0000_0013; rom_mem[1] = 32'h0000_0013; rom_mem[2] = 32'h0000_0013;
    rom_mem[31] = 32'h0100_006F; rom_mem[838] = 32'h0;

    //        rstn req we rdy addr          gnt csn a   rv rdata          err
    tbl.push_back(mk(0, 1, 0, 1, 32'h7C,    0, 1, 0,  0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h7C,    1, 0, 31, 0, 32'h0,          0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  1, 32'h0100_006F,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h00,    1, 0, 0,  0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h04,    1, 0, 1,  1, 32'h13,         0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h08,    1, 0, 2,  1, 32'h13,         0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  1, 32'h13,         0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h7C,    1, 0, 31, 0, 32'h0,          0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 0, 0, 32'h0,   0, 1, 0,  1, 32'h0100_006F,  0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h0,     1, 0, 0,  1, 32'h0100_006F,  0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  1, 32'h13,         0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0,     0, 1, 0,  0, 32'h0,          0));

    adv;
    drive(0, 0, 0, 0, 32'h0);
    adv;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rstn, tbl[i].req, tbl[i].we, tbl[i].rready, tbl[i].addr);
      chk($sformatf("row%0d.gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("row%0d.csn", i), 32'(rom_csn_o), 32'(tbl[i].csn));
      if (!tbl[i].csn || !tbl[i].rstn) chk($sformatf("row%0d.a", i), 32'(rom_a_o), 32'(tbl[i].a));
      chk($sformatf("row%0d.rvalid", i), 32'(rvalid_o), 32'(tbl[i].rvalid));
      if (tbl[i].rvalid || !tbl[i].rstn) begin
        chk($sformatf("row%0d.rdata", i), rdata_o, tbl[i].rdata);
        chk($sformatf("row%0d.err", i), 32'(err_o), 32'(tbl[i].err));
      end
      adv;
    end

    // Write: synthesized response, never selects the ROM.
    drive(1, 1, 1, 1, 32'h10);
    chk("wr.gnt", 32'(gnt_o), 32'd1);
    chk("wr.csn", 32'(rom_csn_o), 32'd1);
    adv;
    drive(1, 0, 0, 1, 32'h0);
    chk("wr.rvalid", 32'(rvalid_o), 32'd1);
    chk("wr.err", 32'(err_o), 32'(ERR_EN));
    chk("wr.rdata", rdata_o, 32'h0);
    chk("wr.csn2", 32'(rom_csn_o), 32'd1);
    adv;

    // Index 839: first word past the ROM.
    drive(1, 1, 0, 1, 32'h0000_0D1C);
    chk("oor.gnt", 32'(gnt_o), 32'd1);
    chk("oor.csn", 32'(rom_csn_o), ERR_EN ? 32'd1 : 32'd0);
    if (!ERR_EN) chk("oor.a", 32'(rom_a_o), 32'd839);
    adv;
    drive(1, 0, 0, 1, 32'h0);
    chk("oor.rvalid", 32'(rvalid_o), 32'd1);
    chk("oor.err", 32'(err_o), 32'(ERR_EN));
    chk("oor.rdata", rdata_o, ERR_EN ? 32'h0 : rom_mem[839]);
    adv;

    // Index 838: last valid word.
    drive(1, 1, 0, 1, 32'h0000_0D18);
    chk("last.csn", 32'(rom_csn_o), 32'd0);
    chk("last.a", 32'(rom_a_o), 32'd838);
    adv;
    drive(1, 0, 0, 1, 32'h0);
    chk("last.rvalid", 32'(rvalid_o), 32'd1);
    chk("last.err", 32'(err_o), 32'd0);
    chk("last.rdata", rdata_o, 32'h0);
    adv;

    // Reset while a response is pending.
    drive(1, 1, 0, 0, 32'h7C);
    adv;
    drive(0, 0, 0, 0, 32'h0);
    chk("rst.pending", 32'(rvalid_o), 32'd1);
    chk("rst.gnt", 32'(gnt_o), 32'd0);
    adv;
    drive(1, 0, 0, 1, 32'h0);
    chk("rst.rvalid0", 32'(rvalid_o), 32'd0);
    chk("rst.rdata", rdata_o, 32'h0);
    chk("rst.err", 32'(err_o), 32'd0);
    adv;
    drive(1, 0, 0, 1, 32'h0);
    chk("rst.rvalid1", 32'(rvalid_o), 32'd0);
    adv;

    // Randomized traffic against a queue-of-expected-responses model.
    exp_q.delete();
    for (int unsigned c = 0; c < 500; c++) begin
      rstn = ($urandom_range(0, 49) != 0);
      req  = ($urandom_range(0, 9) < 7);
      we   = ($urandom_range(0, 99) < 15);
      rdy  = ($urandom_range(0, 9) < 7);
      idx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(836, 841)) : 10'($urandom);
      addr = {20'($urandom), idx, 2'($urandom)};
      drive(rstn, req, we, rdy, addr);

      pending = (exp_q.size() != 0);
      eg      = rstn && req && (!pending || rdy);
      esynth  = we || (ERR_EN && (int'(idx) >= int'(WORDS)));
      chk($sformatf("rnd%0d.gnt", c), 32'(gnt_o), 32'(eg));
      chk($sformatf("rnd%0d.csn", c), 32'(rom_csn_o), 32'(!(eg && !esynth)));
      if (eg && !esynth) chk($sformatf("rnd%0d.a", c), 32'(rom_a_o), 32'(idx));
      chk($sformatf("rnd%0d.rvalid", c), 32'(rvalid_o), 32'(pending));
      if (pending) begin
        chk($sformatf("rnd%0d.rdata", c), rdata_o, exp_q[0].data);
        chk($sformatf("rnd%0d.err", c), 32'(err_o), 32'(exp_q[0].err));
      end

      if (!rstn) exp_q.delete();
      else begin
        if (pending && rdy) void'(exp_q.pop_front());
        if (eg) begin
          r.data = esynth ? 32'h0 : rom_mem[idx];
          r.err  = ERR_EN && esynth;
          exp_q.push_back(r);
        end
      end
      adv;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_rom_bus_adapter.md
BOOT_ROM_BUS_ADAPTER -- requirements
Module: boot_rom_bus_adapter

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 839, number of valid 32-bit ROM words.
REQ-002 SHALL have parameter ROM_AW, default 10, ROM word-address width.
REQ-003 SHALL use one clock; reset is synchronous and active-low: CLK  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port RSTN  input  1  synchronous active-low reset.
REQ-005 SHALL have port req_i  input  1  core request valid.
REQ-006 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port addr_i  input  32  byte address; only [ROM_AW+1:2] decoded.
REQ-008 SHALL have port we_i  input  1  write enable.
REQ-009 SHALL have ports be_i  input  4  and wdata_i  input  32; both ignored.
REQ-010 SHALL have ports rvalid_o  output  1, rready_i  input  1  response handshake.
REQ-011 SHALL have ports rdata_o  output  32, err_o  output  1  response payload.
REQ-012 SHALL have ports rom_csn_o  output  1 (active-low select), rom_a_o  output  ROM_AW, rom_q_i  input  32; the ROM latches rom_a_o on CLK when rom_csn_o=0, and rom_q_i is valid from the next cycle until the next select.

Function
REQ-013 SHALL implement two states: IDLE (no response pending) and RESP (response pending on rvalid_o).
REQ-014 SHALL assert gnt_o = req_i AND (state==IDLE OR rready_i); grant is combinational, with no added wait cycle.
REQ-015 SHALL, on a granted read, drive rom_csn_o=0 and rom_a_o=addr_i[ROM_AW+1:2] in the same cycle; otherwise rom_csn_o=1.
REQ-016 SHALL assert rvalid_o exactly one cycle after grant (latency 1) and hold rvalid_o, rdata_o and err_o stable until rvalid_o AND rready_i.
REQ-017 SHALL drive rdata_o=rom_q_i directly for read responses; Q stability is guaranteed because rom_csn_o stays 1 while a response is pending.
REQ-018 SHALL, on handshake with a simultaneous new grant, stay in RESP (back-to-back, one response per cycle at rready_i=1).
REQ-019 SHALL, on handshake without a new grant, return to IDLE.
REQ-020 SHALL register a 1-bit response-type flag (rom or synthesized) at grant; synthesized responses drive rdata_o=0.
REQ-021 SHALL ignore addr_i[1:0] and addr_i[31:ROM_AW+2].

Reset
REQ-022 SHALL, while RSTN=0 at a rising edge, force state IDLE, rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, rom_csn_o=1, rom_a_o=0.
REQ-023 SHALL drop a pending response on reset mid-operation, with no rvalid_o after RSTN deasserts until a new grant.

Configuration
REQ-024 SHALL, with macro BOOT_ROM_ADAPTER_ERR_EN defined, answer writes and reads with word index >= ROM_WORDS using a synthesized response with err_o=1, rdata_o=0, and no ROM select.
REQ-025 SHALL, without BOOT_ROM_ADAPTER_ERR_EN, tie err_o=0, answer writes with a synthesized rdata_o=0 response, and forward out-of-range reads to the ROM unchanged.

Structure
REQ-026 SHALL place ROM_WORDS/ROM_AW defaults and the IDLE/RESP state enum in package boot_rom_pkg.
REQ-027 SHALL be a single flat module with no sub-modules; the ROM is instantiated beside it by the integrator.

Verification
REQ-028 SHALL cover single read: req_i=1, addr 0x0000_007C, rready_i=1 -> gnt same cycle, rom_a_o=31, next cycle rvalid_o=1, rdata_o=0x0100006F, err_o=0.
REQ-029 SHALL cover a burst: addrs 0x00,0x04,0x08 on consecutive cycles with rready_i=1 -> 3 grants in 3 cycles and 3 rvalid cycles of 0x00000013.
REQ-030 SHALL cover backpressure: rready_i=0 for 4 cycles with req_i held -> gnt_o=0, rom_csn_o=1, rdata_o stable for 4 cycles; rready_i=1 -> handshake plus new grant in the same cycle.
REQ-031 SHALL cover write with macro: we_i=1, addr 0x10 -> rvalid_o after 1 cycle, err_o=1, rdata_o=0, rom_csn_o never 0; without macro -> err_o=0.
REQ-032 SHALL cover out-of-range with macro: addr 0x0000_0D1C (index 839) -> err_o=1; addr 0x0000_0D18 (index 838) -> err_o=0, rdata_o=0x00000000.
REQ-033 SHALL cover reset during RESP: RSTN=0 for 1 cycle -> rvalid_o=0 next cycle and remains 0 with req_i=0.
